// File: rtl/cla_share_arb.sv
// Round-robin arbiter sharing one 64-bit two-level carry-lookahead adder among NREQ requesters.
// Optional subtract support is enabled by defining CLA_SHARE_ARB_SUB_EN.
module cla_share_arb #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*64-1:0] req_a,
    input  logic [NREQ*64-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
`ifdef CLA_SHARE_ARB_SUB_EN
    input  logic [NREQ-1:0]   req_sub,
`endif
    output logic              res_valid,
    input  logic              res_ready,
    output logic [63:0]       res_sum,
    output logic              res_cout,
    output logic [IDW-1:0]    res_id
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_r;
    logic [IDW-1:0]    rr_ptr_r;
    logic [63:0]       sum_r;
    logic              cout_r;
    logic [IDW-1:0]    id_r;

    logic              slot_free_s;
    logic              found_s;
    logic              grant_s;
    logic [IDW-1:0]    win_s;
    logic [IDW:0]      cand_s;
    logic [NREQ-1:0]   rot_s;
    logic [63:0]       a_s;
    logic [63:0]       b_s;
    logic              cin_s;
    logic              sub_s;
    logic [63:0]       b_eff_s;
    logic              cin_eff_s;
    logic [64:0]       add_s;

    // Two-level lookahead: 4-bit groups, 16-bit sections, section carries chained.
    function automatic logic [64:0] cla64(input logic [63:0] a, input logic [63:0] b,
                                          input logic cin);
        logic [63:0] g;
        logic [63:0] p;
        logic [63:0] c;
        logic [15:0] gg;
        logic [15:0] gp;
        logic [15:0] gc;
        logic [3:0]  sg;
        logic [3:0]  sp;
        logic [4:0]  sc;
        g = a & b;
        p = a ^ b;
        for (int j = 0; j < 16; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        for (int k = 0; k < 4; k++) begin
            sg[k] = gg[4*k+3]
                  | (gp[4*k+3] & gg[4*k+2])
                  | (gp[4*k+3] & gp[4*k+2] & gg[4*k+1])
                  | (gp[4*k+3] & gp[4*k+2] & gp[4*k+1] & gg[4*k]);
            sp[k] = &gp[4*k +: 4];
        end
        sc[0] = cin;
        for (int k = 0; k < 4; k++) begin
            sc[k+1] = sg[k] | (sp[k] & sc[k]);
        end
        for (int k = 0; k < 4; k++) begin
            gc[4*k] = sc[k];
            for (int jj = 0; jj < 3; jj++) begin
                gc[4*k+jj+1] = gg[4*k+jj] | (gp[4*k+jj] & gc[4*k+jj]);
            end
        end
        for (int j = 0; j < 16; j++) begin
            c[4*j] = gc[j];
            for (int i = 0; i < 3; i++) begin
                c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
            end
        end
        return {sc[4], p ^ c};
    endfunction

    assign slot_free_s = (state_r == EMPTY) || res_ready;
    assign grant_s     = rst_n && slot_free_s && found_s;

    // Rotating priority scan starting at rr_ptr_r.
    always_comb begin
        rot_s   = NREQ'({req_valid, req_valid} >> rr_ptr_r);
        found_s = 1'b0;
        win_s   = {IDW{1'b0}};
        cand_s  = {(IDW+1){1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            cand_s = {1'b0, rr_ptr_r} + (IDW+1)'(k);
            if (cand_s >= (IDW+1)'(NREQ)) begin
                cand_s = cand_s - (IDW+1)'(NREQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && rot_s[k]) begin
                found_s = 1'b1;
                win_s   = cand_s[IDW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot grant and AND-OR operand mux for the winning requester.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        a_s       = 64'd0;
        b_s       = 64'd0;
        cin_s     = 1'b0;
        sub_s     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_s && (win_s == IDW'(i));
            a_s   = a_s | (req_a[i*64 +: 64] & {64{win_s == IDW'(i)}});
            b_s   = b_s | (req_b[i*64 +: 64] & {64{win_s == IDW'(i)}});
            cin_s = cin_s | (req_cin[i] & (win_s == IDW'(i)));
`ifdef CLA_SHARE_ARB_SUB_EN
            sub_s = sub_s | (req_sub[i] & (win_s == IDW'(i)));
`endif
        end
    end

    // Subtraction is A + ~B + 1; carry-out then means "no borrow".
    always_comb begin
        if (sub_s) begin
            b_eff_s   = ~b_s;
            cin_eff_s = 1'b1;
        end else begin
            b_eff_s   = b_s;
            cin_eff_s = cin_s;
        end
        add_s = cla64(a_s, b_eff_s, cin_eff_s);
    end

    // Result slot state machine, result register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= EMPTY;
            rr_ptr_r <= {IDW{1'b0}};
            sum_r    <= 64'd0;
            cout_r   <= 1'b0;
            id_r     <= {IDW{1'b0}};
        end else if (grant_s) begin
            state_r  <= FULL;
            sum_r    <= add_s[63:0];
            cout_r   <= add_s[64];
            id_r     <= win_s;
            if (win_s == IDW'(NREQ - 1)) begin
                rr_ptr_r <= {IDW{1'b0}};
            end else begin
                rr_ptr_r <= win_s + IDW'(1);
            end
        end else begin
            case (state_r)
                FULL:    state_r <= res_ready ? EMPTY : FULL;
                EMPTY:   state_r <= EMPTY;
                default: state_r <= EMPTY;
            endcase
        end
    end

    assign res_valid = (state_r == FULL);
    assign res_sum   = sum_r;
    assign res_cout  = cout_r;
    assign res_id    = id_r;

endmodule

// File: tb/tb_cla_share_arb.sv
// Self-checking bench for cla_share_arb: directed vector table, hand sequences and
// randomized traffic against a transaction-level reference model.
module tb_cla_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*64-1:0]    req_a;
    logic [NREQ*64-1:0]    req_b;
    logic [NREQ-1:0]       req_cin;
`ifdef CLA_SHARE_ARB_SUB_EN
    logic [NREQ-1:0]       req_sub;
`endif
    logic                  res_valid;
    logic                  res_ready;
    logic [63:0]           res_sum;
    logic                  res_cout;
    logic [IDW-1:0]        res_id;

    cla_share_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef CLA_SHARE_ARB_SUB_EN
        .req_sub   (req_sub),
`endif
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct packed {
        logic            rst;
        logic [NREQ-1:0] rv;
        logic            rr;
        logic [NREQ-1:0] rdy;
        logic            vld;
        logic [IDW-1:0]  id;
    } vec_t;

    vec_t tbl [22];
    int   n_run  = 0;
    int   n_fail = 0;

    // Reference model state: one result slot plus the fairness pointer.
    logic        m_valid = 1'b0;
    logic [63:0] m_sum   = 64'd0;
    logic        m_cout  = 1'b0;
    int          m_id    = 0;
    int          m_ptr   = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int model_grant();
        int c;
        if (!rst_n) return -1;
        if (m_valid && !res_ready) return -1;
        for (int k = 0; k < NREQ; k++) begin
            c = (m_ptr + k) % NREQ;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [64:0] model_result(input int g);
        logic [64:0] a;
        logic [64:0] b;
        a = {1'b0, req_a[g*64 +: 64]};
        b = {1'b0, req_b[g*64 +: 64]};
`ifdef CLA_SHARE_ARB_SUB_EN
        if (req_sub[g]) return a + {1'b0, ~req_b[g*64 +: 64]} + 65'd1;
`endif
        return a + b + {64'd0, req_cin[g]};
    endfunction

    task automatic drive(input logic rst, input logic [NREQ-1:0] rv, input logic rr);
        rst_n     = rst;
        req_valid = rv;
        res_ready = rr;
        for (int i = 0; i < NREQ; i++) begin
            case ($urandom_range(0, 3))
                0:       req_a[i*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
                1:       req_a[i*64 +: 64] = 64'd0;
                default: req_a[i*64 +: 64] = {$urandom, $urandom};
            endcase
            req_b[i*64 +: 64] = ($urandom_range(0, 3) == 0) ? 64'd1 : {$urandom, $urandom};
        end
        req_cin = NREQ'($urandom);
    endtask

    task automatic step(input string tag, input logic use_tbl, input vec_t v);
        logic [NREQ-1:0] exp_rdy;
        logic [64:0]     r;
        int              g;
        #2;
        g       = model_grant();
        exp_rdy = {NREQ{1'b0}};
        if (g >= 0) exp_rdy[g] = 1'b1;
        r = (g >= 0) ? model_result(g) : 65'd0;
        chk({tag, " req_ready"}, 65'(req_ready), 65'(use_tbl ? v.rdy : exp_rdy));
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0; m_sum = 64'd0; m_cout = 1'b0; m_id = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1; m_sum = r[63:0]; m_cout = r[64]; m_id = g;
            m_ptr = (g + 1) % NREQ;
        end else if (m_valid && res_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk({tag, " res_valid"}, 65'(res_valid), 65'(use_tbl ? v.vld : m_valid));
        chk({tag, " res_id"}, 65'(res_id), 65'(use_tbl ? v.id : IDW'(m_id)));
        chk({tag, " res_sum/cout"}, {res_cout, res_sum}, {m_cout, m_sum});
    endtask

    // Guards against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        vec_t none_v;
        none_v = vec_t'(13'd0);
        //           rst   rv     rr    rdy    vld   id
        tbl[0]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0};
        tbl[2]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0};
        tbl[3]  = '{1'b1, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1};
        tbl[4]  = '{1'b1, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2};
        tbl[5]  = '{1'b1, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3};
        tbl[6]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0};
        tbl[7]  = '{1'b1, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1};
        tbl[8]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1};
        tbl[9]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1};
        tbl[10] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1};
        tbl[11] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1};
        tbl[12] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1};
        tbl[13] = '{1'b1, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2};
        tbl[14] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 2'd2};
        tbl[15] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 2'd2};
        tbl[16] = '{1'b1, 4'h4, 1'b0, 4'h4, 1'b1, 2'd2};
        tbl[17] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0};
        tbl[18] = '{1'b1, 4'hA, 1'b0, 4'h2, 1'b1, 2'd1};
        tbl[19] = '{1'b1, 4'hA, 1'b0, 4'h0, 1'b1, 2'd1};
        tbl[20] = '{1'b1, 4'h8, 1'b1, 4'h8, 1'b1, 2'd3};
        tbl[21] = '{1'b1, 4'h1, 1'b1, 4'h1, 1'b1, 2'd0};

`ifdef CLA_SHARE_ARB_SUB_EN
        req_sub = {NREQ{1'b0}};
`endif
        for (int t = 0; t < 22; t++) begin
            drive(tbl[t].rst, tbl[t].rv, tbl[t].rr);
            step($sformatf("tbl%0d", t), 1'b1, tbl[t]);
        end

        // All-ones plus one wraps to zero with carry-out.
        drive(1'b1, 4'h2, 1'b1);
        req_a[64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
        req_b[64 +: 64] = 64'd1;
        req_cin[1]      = 1'b0;
        step("single_add", 1'b0, none_v);
        chk("single_add sum", 65'(res_sum), 65'd0);
        chk("single_add cout", 65'(res_cout), 65'd1);
        chk("single_add id", 65'(res_id), 65'd1);

`ifdef CLA_SHARE_ARB_SUB_EN
        drive(1'b1, 4'h8, 1'b1);
        req_sub = 4'h8;
        req_a[192 +: 64] = 64'd5;
        req_b[192 +: 64] = 64'd7;
        step("sub_neg", 1'b0, none_v);
        chk("sub_neg sum", 65'(res_sum), 65'(64'hFFFF_FFFF_FFFF_FFFE));
        chk("sub_neg cout", 65'(res_cout), 65'd0);
        drive(1'b1, 4'h8, 1'b1);
        req_a[192 +: 64] = 64'd7;
        req_b[192 +: 64] = 64'd5;
        step("sub_pos", 1'b0, none_v);
        chk("sub_pos sum", 65'(res_sum), 65'd2);
        chk("sub_pos cout", 65'(res_cout), 65'd1);
`endif

        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 39) != 0, NREQ'($urandom), $urandom_range(0, 3) != 0);
`ifdef CLA_SHARE_ARB_SUB_EN
            req_sub = NREQ'($urandom);
`endif
            step($sformatf("rand%0d", n), 1'b0, none_v);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_share_arb.md
# cla_share_arb

Round-robin arbiter and sequencer that shares a single 64-bit carry-lookahead adder instance among `NREQ` requesters. It sits between the partial-product/accumulate stages of the multiplier datapath and the one physical adder. It accepts at most one operand pair per cycle and registers the sum with requester tag. It presents the result on a valid/ready output port.

## Interface
- `NREQ`, 4: number of requesters; legal range 2..8.
- `IDW`, `$clog2(NREQ)`: width of the requester tag, derived and not overridden.
- `clk`  input  1  sole clock; all state changes on its rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `req_valid`  input  NREQ  requester i presents operands.
- `req_ready`  output  NREQ  one-hot grant; handshake completes for i when `req_valid[i] & req_ready[i]`.
- `req_a`  input  NREQ*64  operand A, requester i at bits [64i+63:64i].
- `req_b`  input  NREQ*64  operand B, same packing.
- `req_cin`  input  NREQ  carry-in per requester.
- `res_valid`  output  1  result register holds an undelivered result.
- `res_ready`  input  1  consumer accepts the result.
- `res_sum`  output  64  registered sum.
- `res_cout`  output  1  registered carry-out.
- `res_id`  output  IDW  index of the requester that produced the result.

## Operation
- Two states: EMPTY (`res_valid`=0) and FULL (`res_valid`=1).
- Slot free when EMPTY, or when FULL with `res_ready`=1 in the same cycle (pass-through refill).
- Arbitration is combinational and happens only when the slot is free. The winner is the first i with `req_valid[i]`=1, scanning from `rr_ptr` upward and wrapping modulo NREQ.
- `req_ready` is one-hot for the winner and all zeros otherwise. It is never asserted while the slot is not free.
- The winner's A, B and cin drive the single adder instance. Sum, carry-out and index load into the result register at the clock edge.
- After a grant to i: `rr_ptr` = (i+1) mod NREQ. Without a grant, `rr_ptr` holds.
- FULL with `res_ready`=1 and no request: next state EMPTY. Outputs `res_sum`, `res_cout` and `res_id` hold their last values.
- FULL with `res_ready`=0: all result outputs are stable and `req_ready`=0.
- Arithmetic is modulo 2^64. `res_cout` is bit 64 of A+B+cin.
- A requester may drop `req_valid` without penalty. No state is kept for ungranted requesters.

## Timing
- Reset (`rst_n`=0 at an edge): `res_valid`=0, `res_sum`=0, `res_cout`=0, `res_id`=0, `rr_ptr`=0.
  - `req_ready` is forced to 0 during any cycle with `rst_n`=0.
  - Reset mid-transfer discards the held result.
- Latency: grant at edge N gives `res_valid`=1 with the result after edge N.
- Throughput: one result per cycle with `res_ready` held at 1.
- Simultaneous drain and refill: the old result is consumed and the new result loaded at the same edge. `res_valid` stays 1.
- `req_ready` depends combinationally on `req_valid`, `res_valid`, `res_ready` and `rr_ptr`. `res_*` outputs are registered only.

## Configuration
- `CLA_SHARE_ARB_SUB_EN` defined:
  - Adds input `req_sub` [NREQ-1:0].
  - When the granted requester's `req_sub`=1, the adder receives ~B and carry-in 1, and `req_cin` is ignored. The result is A−B, and `res_cout`=1 means no borrow.
  - When `req_sub`=0, behaviour is addition as specified above.
- Undefined: port `req_sub` is absent and the adder always computes A+B+cin.

## Test plan
- Reset then idle: hold `rst_n`=0 for 2 cycles with all `req_valid`=1 -> `req_ready`=0 and `res_valid`=0. First grant after release goes to requester 0.
- Single add: req 1 with A=0xFFFF_FFFF_FFFF_FFFF, B=1, cin=0 -> one cycle later `res_sum`=0, `res_cout`=1, `res_id`=1.
- Round-robin fairness: all four requesters valid continuously with `res_ready`=1 -> grant order 0,1,2,3,0,1. Four results in four consecutive cycles with `res_valid` never dropping.
- Backpressure: `res_ready`=0 for 5 cycles while FULL -> `req_ready`=0 and result outputs unchanged. On `res_ready`=1 a new grant and drain occur in the same edge.
- Reset mid-operation: FULL with `res_id`=2, assert `rst_n`=0 for one edge -> `res_valid`=0 and `rr_ptr`=0. The next grant goes to the lowest valid index.
- With `CLA_SHARE_ARB_SUB_EN`: req 3, A=5, B=7, `req_sub`=1 -> `res_sum`=0xFFFF_FFFF_FFFF_FFFE, `res_cout`=0. A=7, B=5 -> `res_sum`=2, `res_cout`=1.
